pattern_sequencer: RTL and testbench

Parametrised successor to the fixed three-pattern selector. Sequences NUM_PATTERNS generators with per-pattern frame durations, supports manual next/previous stepping, and applies every switch at a VGA frame boundary (vsync rising edge). Sits between the VGA timing block and the pattern generators, driving their animation triggers and resets and muxing their RGB onto the output path.

---
 rtl/pattern_pkg.sv | 15 +
 rtl/pattern_sequencer_if.sv | 35 +++
 rtl/vsync_edge.sv | 20 ++
 rtl/pattern_sequencer.sv | 134 +++++++++++++
 tb/tb_pattern_sequencer.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/pattern_pkg.sv
// Shared constants and request encoding for the pattern sequencer and its
// surrounding generator blocks.
package pattern_pkg;

  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_NEXT = 2'd1,
    REQ_PREV = 2'd2
  } req_e;

  localparam int DEFAULT_NUM_PATTERNS = 4;
  localparam int DEFAULT_FRAME_W      = 10;
  localparam int DEFAULT_RGB_W        = 6;

endpackage

// File: rtl/pattern_sequencer_if.sv
// Signal bundle between the VGA timing / control side (master) and the
// pattern sequencer (slave).
interface pattern_sequencer_if
  import pattern_pkg::*;
#(
  parameter int NUM_PATTERNS = DEFAULT_NUM_PATTERNS,
  parameter int FRAME_W      = DEFAULT_FRAME_W,
  parameter int RGB_W        = DEFAULT_RGB_W
) ();
  localparam int SEL_W = $clog2(NUM_PATTERNS);

  logic                            vsync;
  logic                            paused;
  logic                            auto_en;
  logic                            next_req;
  logic                            prev_req;
  logic [NUM_PATTERNS*FRAME_W-1:0] durations;
  logic [NUM_PATTERNS*RGB_W-1:0]   pattern_rgb;
  logic [RGB_W-1:0]                rgb;
  logic [SEL_W-1:0]                pattern_sel;
  logic [NUM_PATTERNS-1:0]         next_frame;
  logic [NUM_PATTERNS-1:0]         pattern_rst;
  logic [FRAME_W-1:0]              frame_count;
  logic                            wrap;

  modport master (
    output vsync, paused, auto_en, next_req, prev_req, durations, pattern_rgb,
    input  rgb, pattern_sel, next_frame, pattern_rst, frame_count, wrap
  );

  modport slave (
    input  vsync, paused, auto_en, next_req, prev_req, durations, pattern_rgb,
    output rgb, pattern_sel, next_frame, pattern_rst, frame_count, wrap
  );
endinterface

// File: rtl/vsync_edge.sv
// Frame-boundary detector: one-cycle tick on the rising edge of vsync.
// The history register resets high so a high vsync at reset release is not an edge.
module vsync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync,
  output logic tick
);
  logic vsync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
    end else begin
      vsync_q <= vsync;
    end
  end

  assign tick = vsync & ~vsync_q;
endmodule

// File: rtl/pattern_sequencer.sv
// Sequences NUM_PATTERNS generators, switching only at vsync rising edges.
// Optional PATTERN_SEQ_BLANK_EN inserts one black, non-animated frame after each switch.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int NUM_PATTERNS = DEFAULT_NUM_PATTERNS,
  parameter int FRAME_W      = DEFAULT_FRAME_W,
  parameter int RGB_W        = DEFAULT_RGB_W
) (
  input logic                clk,
  input logic                rst_n,
  pattern_sequencer_if.slave bus
);
  localparam int                      SEL_W    = $clog2(NUM_PATTERNS);
  localparam logic [SEL_W-1:0]        LAST_SEL = SEL_W'(NUM_PATTERNS - 1);
  localparam logic [NUM_PATTERNS-1:0] ONE_HOT0 = NUM_PATTERNS'(1);

  logic                    tick;
  req_e                    pending_reg, pending_next;
  logic [SEL_W-1:0]        sel_reg, sel_next, sel_inc, sel_dec;
  logic [FRAME_W-1:0]      count_reg, count_next, eff_dur;
  logic [NUM_PATTERNS-1:0] rst_reg, rst_next;
  logic                    wrap_reg, wrap_next;
  logic                    do_switch;
  logic                    blank;
  logic [FRAME_W-1:0]      dur_arr [NUM_PATTERNS];
  logic [RGB_W-1:0]        rgb_arr [NUM_PATTERNS];

  generate
    for (genvar gi = 0; gi < NUM_PATTERNS; gi++) begin : g_unpack
      assign dur_arr[gi] = bus.durations[gi*FRAME_W +: FRAME_W];
      assign rgb_arr[gi] = bus.pattern_rgb[gi*RGB_W +: RGB_W];
    end
  endgenerate

  vsync_edge u_vsync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .vsync (bus.vsync),
    .tick  (tick)
  );

  // Pending manual request; a request landing in a tick cycle survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_reg <= REQ_NONE;
    end else begin
      pending_reg <= pending_next;
    end
  end

  always_comb begin
    pending_next = pending_reg;
    if (tick) begin
      pending_next = REQ_NONE;
    end
    if (bus.next_req && !bus.prev_req) begin
      pending_next = REQ_NEXT;
    end else if (bus.prev_req && !bus.next_req) begin
      pending_next = REQ_PREV;
    end
  end

  assign eff_dur = (dur_arr[sel_reg] == '0) ? FRAME_W'(1) : dur_arr[sel_reg];
  assign sel_inc = (sel_reg == LAST_SEL) ? '0 : sel_reg + SEL_W'(1);
  assign sel_dec = (sel_reg == '0) ? LAST_SEL : sel_reg - SEL_W'(1);

  always_comb begin
    sel_next   = sel_reg;
    count_next = count_reg;
    wrap_next  = 1'b0;
    do_switch  = 1'b0;
    if (tick) begin
      if (pending_reg == REQ_NEXT) begin
        sel_next   = sel_inc;
        count_next = '0;
        do_switch  = 1'b1;
      end else if (pending_reg == REQ_PREV) begin
        sel_next   = sel_dec;
        count_next = '0;
        do_switch  = 1'b1;
      end else if (bus.auto_en) begin
        // >= so a duration lowered below the running count still switches
        if (count_reg >= eff_dur - FRAME_W'(1)) begin
          sel_next   = sel_inc;
          count_next = '0;
          wrap_next  = (sel_reg == LAST_SEL);
          do_switch  = 1'b1;
        end else begin
          count_next = count_reg + FRAME_W'(1);
        end
      end
    end
    rst_next = do_switch ? (ONE_HOT0 << sel_next) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_reg   <= '0;
      count_reg <= '0;
      rst_reg   <= '0;
      wrap_reg  <= 1'b0;
    end else begin
      sel_reg   <= sel_next;
      count_reg <= count_next;
      rst_reg   <= rst_next;
      wrap_reg  <= wrap_next;
    end
  end

`ifdef PATTERN_SEQ_BLANK_EN
  logic blank_reg;

  // Set by a switch, cleared by the following tick: exactly one dark frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank_reg <= 1'b0;
    end else if (tick) begin
      blank_reg <= do_switch;
    end
  end

  assign blank = blank_reg;
`else
  assign blank = 1'b0;
`endif

  assign bus.next_frame  = (tick && !bus.paused && !blank) ? (ONE_HOT0 << sel_reg) : '0;
  assign bus.rgb         = blank ? '0 : rgb_arr[sel_reg];
  assign bus.pattern_sel = sel_reg;
  assign bus.frame_count = count_reg;
  assign bus.pattern_rst = rst_reg;
  assign bus.wrap        = wrap_reg;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Scoreboard bench for pattern_sequencer (3 patterns); frame() queues the expected
// per-tick result, the monitor checks it at the tick and one cycle after.
module tb_pattern_sequencer;
  localparam int P  = 3;
  localparam int FW = 10;
  localparam int RW = 6;

  typedef struct {
    logic [P-1:0]  nf;
    logic [1:0]    sel;
    logic [FW-1:0] cnt;
    logic          wrap;
    logic [P-1:0]  rs;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tb_vq;
  logic tb_blank;
  logic post_chk;
  logic after_chk;
  int   checks = 0;
  int   errors = 0;
  int   tick_no = 0;
  exp_t sb_q[$];
  exp_t cur;
  logic [RW-1:0] prgb [P];

  always #5 clk = ~clk;

  pattern_sequencer_if #(.NUM_PATTERNS(P), .FRAME_W(FW), .RGB_W(RW)) bus ();

  pattern_sequencer #(.NUM_PATTERNS(P), .FRAME_W(FW), .RGB_W(RW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_vq <= 1'b1;
    else        tb_vq <= bus.vsync;
  end

  // Monitor: next_frame checked in the tick cycle, registered outputs one cycle later,
  // and the one-cycle pulses confirmed low the cycle after that.
  always @(negedge clk) begin
    if (!rst_n) begin
      post_chk  = 1'b0;
      after_chk = 1'b0;
      tb_blank  = 1'b0;
    end else begin
      if (post_chk) begin
        $display("tick %0d: sel=%0d count=%0d wrap=%0b rst=%b (exp sel=%0d count=%0d wrap=%0b rst=%b)",
                 tick_no, bus.pattern_sel, bus.frame_count, bus.wrap, bus.pattern_rst,
                 cur.sel, cur.cnt, cur.wrap, cur.rs);
        chk("pattern_sel", 32'(bus.pattern_sel), 32'(cur.sel));
        chk("frame_count", 32'(bus.frame_count), 32'(cur.cnt));
        chk("wrap",        32'(bus.wrap),        32'(cur.wrap));
        chk("pattern_rst", 32'(bus.pattern_rst), 32'(cur.rs));
        chk("rgb",         32'(bus.rgb),         tb_blank ? 32'd0 : 32'(prgb[cur.sel]));
        post_chk  = 1'b0;
        after_chk = 1'b1;
      end else if (after_chk) begin
        chk("pattern_rst_pulse", 32'(bus.pattern_rst), 32'd0);
        chk("wrap_pulse",        32'(bus.wrap),        32'd0);
        after_chk = 1'b0;
      end
      if (bus.vsync && !tb_vq) begin
        tick_no++;
        if (sb_q.size() == 0) begin
          chk("unexpected_tick", 32'd1, 32'd0);
        end else begin
          cur = sb_q.pop_front();
`ifdef PATTERN_SEQ_BLANK_EN
          chk("next_frame", 32'(bus.next_frame), tb_blank ? 32'd0 : 32'(cur.nf));
          tb_blank = (cur.rs != '0);
`else
          chk("next_frame", 32'(bus.next_frame), 32'(cur.nf));
`endif
          post_chk = 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync low 4 cycles then high 4; requests mid-frame or in the tick cycle.
  task automatic frame(input logic [P-1:0] nf, input logic [1:0] sel, input logic [FW-1:0] cnt,
                       input logic wrap, input logic [P-1:0] rs,
                       input logic nreq = 1'b0, input logic preq = 1'b0, input logic at_tick = 1'b0);
    exp_t e;
    e.nf = nf; e.sel = sel; e.cnt = cnt; e.wrap = wrap; e.rs = rs;
    sb_q.push_back(e);
    bus.vsync = 1'b0;
    step();
    if (!at_tick) begin
      bus.next_req = nreq;
      bus.prev_req = preq;
    end
    step();
    bus.next_req = 1'b0;
    bus.prev_req = 1'b0;
    repeat (2) step();
    bus.vsync = 1'b1;
    if (at_tick) begin
      bus.next_req = nreq;
      bus.prev_req = preq;
    end
    step();
    bus.next_req = 1'b0;
    bus.prev_req = 1'b0;
    repeat (3) step();
  endtask

  task automatic pulse(input logic nreq, input logic preq);
    bus.next_req = nreq;
    bus.prev_req = preq;
    step();
    bus.next_req = 1'b0;
    bus.prev_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    prgb[0] = 6'h11; prgb[1] = 6'h22; prgb[2] = 6'h33;
    bus.vsync       = 1'b1;
    bus.paused      = 1'b0;
    bus.auto_en     = 1'b1;
    bus.next_req    = 1'b0;
    bus.prev_req    = 1'b0;
    bus.durations   = {10'd1, 10'd3, 10'd2};
    bus.pattern_rgb = {prgb[2], prgb[1], prgb[0]};
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_sel",   32'(bus.pattern_sel), 32'd0);
    chk("reset_count", 32'(bus.frame_count), 32'd0);
    chk("reset_prst",  32'(bus.pattern_rst), 32'd0);
    chk("reset_wrap",  32'(bus.wrap),        32'd0);
    chk("reset_nf",    32'(bus.next_frame),  32'd0);
    chk("reset_rgb",   32'(bus.rgb),         32'(prgb[0]));
    step();

    // Auto sequence with durations {2,3,1}
    frame(3'b001, 2'd0, 10'd1, 1'b0, 3'b000);
    frame(3'b001, 2'd1, 10'd0, 1'b0, 3'b010);
    frame(3'b010, 2'd1, 10'd1, 1'b0, 3'b000);
    frame(3'b010, 2'd1, 10'd2, 1'b0, 3'b000);
    frame(3'b010, 2'd2, 10'd0, 1'b0, 3'b100);
    frame(3'b100, 2'd0, 10'd0, 1'b1, 3'b001);

    // Manual stepping with the counter frozen
    bus.auto_en = 1'b0;
    frame(3'b001, 2'd0, 10'd0, 1'b0, 3'b000);
    frame(3'b001, 2'd1, 10'd0, 1'b0, 3'b010, 1'b1, 1'b0);
    frame(3'b010, 2'd2, 10'd0, 1'b0, 3'b100, 1'b1, 1'b0);
    frame(3'b100, 2'd0, 10'd0, 1'b0, 3'b001, 1'b1, 1'b0);
    frame(3'b001, 2'd2, 10'd0, 1'b0, 3'b100, 1'b0, 1'b1);
    frame(3'b100, 2'd2, 10'd0, 1'b0, 3'b000, 1'b1, 1'b1);
    pulse(1'b0, 1'b1);
    frame(3'b100, 2'd0, 10'd0, 1'b0, 3'b001, 1'b1, 1'b0);
    frame(3'b001, 2'd0, 10'd0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    frame(3'b001, 2'd1, 10'd0, 1'b0, 3'b010);

    // Paused: triggers gated, sequencing continues
    bus.auto_en = 1'b1;
    bus.paused  = 1'b1;
    frame(3'b000, 2'd1, 10'd1, 1'b0, 3'b000);
    frame(3'b000, 2'd1, 10'd2, 1'b0, 3'b000);
    frame(3'b000, 2'd2, 10'd0, 1'b0, 3'b100);
    frame(3'b000, 2'd0, 10'd0, 1'b1, 3'b001);
    bus.paused = 1'b0;

    // Duration lowered below the running count, then a zero duration
    bus.durations = {10'd1, 10'd3, 10'd10};
    for (int i = 1; i <= 5; i++) begin
      frame(3'b001, 2'd0, FW'(i), 1'b0, 3'b000);
    end
    bus.durations = {10'd1, 10'd3, 10'd2};
    frame(3'b001, 2'd1, 10'd0, 1'b0, 3'b010);
    bus.durations = {10'd1, 10'd0, 10'd2};
    frame(3'b010, 2'd2, 10'd0, 1'b0, 3'b100);
    frame(3'b100, 2'd0, 10'd0, 1'b1, 3'b001);

    // Reset mid-frame right after a switch, released with vsync high
    frame(3'b001, 2'd1, 10'd0, 1'b0, 3'b010, 1'b1, 1'b0);
    bus.vsync = 1'b0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_sel",   32'(bus.pattern_sel), 32'd0);
    chk("midrst_count", 32'(bus.frame_count), 32'd0);
    chk("midrst_rgb",   32'(bus.rgb),         32'(prgb[0]));
    chk("midrst_prst",  32'(bus.pattern_rst), 32'd0);
    bus.vsync = 1'b1;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("release_nf",  32'(bus.next_frame),  32'd0);
      chk("release_sel", 32'(bus.pattern_sel), 32'd0);
    end
    step();
    repeat (4) step();
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
